// File: rtl/io_pass_sync.sv
// Per-channel input synchroniser, debouncer and edge detector.
// Macro IO_PASS_SYNC_DEBOUNCE_EN enables the debounce counters; undefined, out follows sync.
module io_pass_sync #(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   // Parameter sanity check at elaboration.
   if (WIDTH < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("io_pass_sync: illegal parameter combination");
   end

   logic [WIDTH-1:0] stage_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_c;
   logic [WIDTH-1:0] out_d;

   // Synchroniser chain; stage 0 samples the raw asynchronous levels.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int s = 0; s < int'(SYNC_STAGES); s++) stage_q[s] <= '0;
      end else begin
         stage_q[0] <= in;
         for (int s = 1; s < int'(SYNC_STAGES); s++) stage_q[s] <= stage_q[s-1];
      end
   end

   assign sync_c = stage_q[SYNC_STAGES-1];

`ifdef IO_PASS_SYNC_DEBOUNCE_EN
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CW-1:0] cnt_q [WIDTH];
   logic [CW-1:0] cnt_d [WIDTH];

   // Count consecutive mismatch cycles; adopt sync only after a full stable run.
   always_comb begin
      out_d = out;
      for (int i = 0; i < int'(WIDTH); i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync_c[i] == out[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            out_d[i] = sync_c[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
      end
   end
`else
   always_comb begin
      out_d = sync_c;
   end
`endif

   // Level and edge pulses change on the same edge, all from flops.
   always_ff @(posedge clock) begin
      if (reset) begin
         out  <= '0;
         rise <= '0;
         fall <= '0;
      end else begin
         out  <= out_d;
         rise <= out_d & ~out;
         fall <= ~out_d & out;
      end
   end

endmodule

// File: doc/io_pass_sync.md
IO_PASS_SYNC -- requirements
Module: io_pass_sync

Interface
REQ-001 Parameter WIDTH, default 8, number of independent channels; WIDTH >= 1.
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flop depth per channel; SYNC_STAGES >= 2.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required before out changes; DEBOUNCE_CYCLES >= 1.
REQ-004 clock  input  1  single clock for all logic.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in  input  WIDTH  asynchronous raw levels (pins, buttons, PS GPIO).
REQ-007 out  output  WIDTH  synchronised, debounced level, registered.
REQ-008 rise  output  WIDTH  one-cycle pulse per channel on out 0->1, registered.
REQ-009 fall  output  WIDTH  one-cycle pulse per channel on out 1->0, registered.

Function
REQ-010 Each channel i SHALL be fully independent; no state is shared between channels.
REQ-011 Each channel SHALL pass in[i] through a chain of SYNC_STAGES flops; sync[i] denotes the last stage.
REQ-012 Per channel, a counter of width clog2(DEBOUNCE_CYCLES+1) SHALL update on each rising edge: if sync == out, cnt <= 0; else if cnt == DEBOUNCE_CYCLES-1, out <= sync and cnt <= 0; else cnt <= cnt+1.
REQ-013 Latency: for a level held stable, with the first edge that samples the new level counted as edge 1, out SHALL change at edge SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-014 Any mismatch run shorter than DEBOUNCE_CYCLES cycles SHALL clear the counter and SHALL leave out and the pulses unchanged.
REQ-015 The counter SHALL never exceed DEBOUNCE_CYCLES-1, so it cannot wrap.
REQ-016 rise[i] SHALL be 1 for exactly the first cycle in which out[i] is 1 after being 0; fall[i] is defined likewise for 1->0. Both SHALL be 0 in all other cycles.
REQ-017 rise[i] and fall[i] SHALL never be asserted in the same cycle.
REQ-018 Simultaneous transitions on several channels SHALL produce same-cycle pulses on each channel, with no arbitration.
REQ-019 out SHALL be glitch-free: each bit is driven directly from a flop.

Reset
REQ-020 While reset is high at a rising edge, all sync flops, counters, out, rise and fall SHALL be cleared to 0, regardless of in.
REQ-021 Reset asserted mid-count SHALL discard the partial count. After release, a held input SHALL require the full latency of REQ-013 again.
REQ-022 No output SHALL pulse in the first cycle after reset release unless REQ-013 is satisfied.

Configuration
REQ-023 Macro IO_PASS_SYNC_DEBOUNCE_EN defined: debounce counters present and behaviour per REQ-012..REQ-014.
REQ-024 Macro IO_PASS_SYNC_DEBOUNCE_EN undefined:
- no counters are instantiated and DEBOUNCE_CYCLES is ignored;
- out <= sync on every edge, i.e. identical to DEBOUNCE_CYCLES = 1;
- latency SHALL be SYNC_STAGES+1 edges;
- rise and fall behaviour is unchanged.

Verification (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-025 Reset held 3 cycles with in=4'hF -> out=4'h0, rise=fall=4'h0 during reset and in the first cycle after release.
REQ-026 in[0] 0->1 and held -> out[0]=1 at edge 6; rise[0]=1 for one cycle at that edge; out[3:1], rise[3:1] and fall stay 0. in[0] 1->0 later -> fall[0] pulses at edge 6 after the change.
REQ-027 in[1] high for 3 cycles then low -> out[1] stays 0; no rise or fall pulse on any channel.
REQ-028 in 4'h0 -> 4'hF at one edge -> out=4'hF at edge 6; rise=4'hF for exactly one cycle.
REQ-029 in[2] high; reset pulsed for 1 cycle at edge 4 -> out[2]=0. out[2]=1 at edge 6 counted from the first post-reset sampling edge.
REQ-030 Macro undefined: in[0] step -> out[0]=1 at edge 3. A 1-cycle in[0] pulse -> 1-cycle out[0] pulse, with rise[0] and fall[0] in consecutive cycles.
